// File: rtl/tz_clock_counter.sv
// ============================================================================
// Module   : tz_clock_counter
// Purpose  : GMT time-of-day counter with prescaled 1 s tick, field set and
//            saturating whole-hour timezone offset producing local time.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tz_clock_counter #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int RESET_HOUR = 15,
    parameter int TZ_RESET   = 9,
    parameter int TZ_MIN     = -12,
    parameter int TZ_MAX     = 14
) (
    input  logic        RESETN,
    input  logic        CLK,
    input  logic        RUN,
    input  logic        SET_EN,
    input  logic [1:0]  SET_SEL,
    input  logic [5:0]  SET_VAL,
    input  logic        TZ_INC,
    input  logic        TZ_DEC,
    output logic [17:0] GMT_DATA,
    output logic [17:0] LOCAL_DATA,
    output logic [4:0]  TZ_OFFSET,
    output logic        SEC_PULSE,
    output logic        DAY_ROLL,
    output logic        SET_ERR
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]     c_PRESC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [5:0]        c_RESET_HOUR  = 6'(RESET_HOUR);
    localparam logic [5:0]        c_RESET_LOCAL = 6'((((RESET_HOUR + TZ_RESET) % 24) + 24) % 24);
    localparam logic signed [4:0] c_TZ_RESET    = 5'(TZ_RESET);
    localparam logic signed [4:0] c_TZ_MIN      = 5'(TZ_MIN);
    localparam logic signed [4:0] c_TZ_MAX      = 5'(TZ_MAX);

    // Operand ranges keep the sum within -24..47, so one correction suffices.
    function automatic logic [5:0] f_mod24(input logic signed [6:0] v);
        logic signed [6:0] r;
        r = v;
        if (v < 7'sd0) begin
            r = v + 7'sd24;
        end else if (v >= 7'sd24) begin
            r = v - 7'sd24;
        end
        return 6'(r);
    endfunction

    logic [PW-1:0]     presc_q, presc_d;
    logic [5:0]        sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic signed [4:0] tz_q, tz_d;
    logic [5:0]        loc_hour_q, loc_hour_d, loc_min_q, loc_min_d, loc_sec_q, loc_sec_d;
    logic              sec_pulse_q, sec_pulse_d;
    logic              day_roll_q, day_roll_d;
    logic              set_err_q, set_err_d;

    logic              w_tick;
    logic              w_set_ok;
    logic signed [6:0] w_tz_ext;
    logic signed [6:0] w_set_val_ext;
    logic signed [6:0] w_hour_ext;

    assign w_tick        = RUN && (presc_q == c_PRESC_LAST);
    assign w_tz_ext      = {{2{tz_q[4]}}, tz_q};
    assign w_set_val_ext = {1'b0, SET_VAL};
    assign w_hour_ext    = {1'b0, hour_q};

    always_comb begin
        case (SET_SEL)
            2'd0, 2'd1: w_set_ok = (SET_VAL <= 6'd59);
            2'd2:       w_set_ok = (SET_VAL <= 6'd23);
            default:    w_set_ok = 1'b0;
        endcase
    end

    always_comb begin
        presc_d     = presc_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        sec_pulse_d = 1'b0;
        day_roll_d  = 1'b0;
        set_err_d   = 1'b0;

        if (SET_EN) begin
            presc_d = '0;
            if (w_set_ok) begin
                case (SET_SEL)
                    2'd0:    sec_d  = SET_VAL;
                    2'd1:    min_d  = SET_VAL;
                    default: hour_d = f_mod24(w_set_val_ext - w_tz_ext);
                endcase
            end else begin
                set_err_d = 1'b1;
            end
        end else if (!RUN) begin
            presc_d = '0;
        end else if (w_tick) begin
            presc_d     = '0;
            sec_pulse_d = 1'b1;
            sec_d       = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
            if (sec_q == 6'd59) begin
                min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                if (min_q == 6'd59) begin
                    hour_d     = (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
                    day_roll_d = (hour_q == 6'd23);
                end
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_comb begin
        tz_d = tz_q;
        if (TZ_INC && !TZ_DEC && (tz_q < c_TZ_MAX)) begin
            tz_d = tz_q + 5'sd1;
        end else if (TZ_DEC && !TZ_INC && (tz_q > c_TZ_MIN)) begin
            tz_d = tz_q - 5'sd1;
        end
    end

    // Local time samples the current GMT and offset, giving a one-cycle lag.
    always_comb begin
        loc_hour_d = f_mod24(w_hour_ext + w_tz_ext);
        loc_min_d  = min_q;
        loc_sec_d  = sec_q;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            presc_q     <= '0;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hour_q      <= c_RESET_HOUR;
            tz_q        <= c_TZ_RESET;
            loc_hour_q  <= c_RESET_LOCAL;
            loc_min_q   <= 6'd0;
            loc_sec_q   <= 6'd0;
            sec_pulse_q <= 1'b0;
            day_roll_q  <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            tz_q        <= tz_d;
            loc_hour_q  <= loc_hour_d;
            loc_min_q   <= loc_min_d;
            loc_sec_q   <= loc_sec_d;
            sec_pulse_q <= sec_pulse_d;
            day_roll_q  <= day_roll_d;
            set_err_q   <= set_err_d;
        end
    end

    assign GMT_DATA   = {hour_q, min_q, sec_q};
    assign LOCAL_DATA = {loc_hour_q, loc_min_q, loc_sec_q};
    assign TZ_OFFSET  = tz_q;
    assign SEC_PULSE  = sec_pulse_q;
    assign DAY_ROLL   = day_roll_q;
    assign SET_ERR    = set_err_q;

endmodule

`default_nettype wire

// File: doc/tz_clock_counter.md
Name: tz_clock_counter

Overview:
- Parametrised time-of-day counter for the clock datapath.
- Keeps a master time in GMT (hour/min/sec) that advances on an internal once-per-second tick, derived by prescaling CLK.
- Supports direct field setting and a signed whole-hour timezone offset; outputs both GMT and local time as packed {hour,min,sec}.
- Feeds the display formatter and alarm compare logic.

Parameters:
- TICK_DIV, 50_000_000, CLK cycles per one-second tick; legal range ≥1.
- RESET_HOUR, 15, GMT hour loaded on reset; legal range 0..23.
- TZ_RESET, 9, timezone offset loaded on reset, in hours.
- TZ_MIN, -12, lowest allowed timezone offset, in hours.
- TZ_MAX, 14, highest allowed timezone offset, in hours.

Ports:
- RESETN  in  1  asynchronous active-low reset
- CLK  in  1  system clock
- RUN  in  1  1 = time advances on tick; 0 = time frozen, prescaler held at 0
- SET_EN  in  1  one-cycle strobe: load SET_VAL into the field chosen by SET_SEL
- SET_SEL  in  2  field select: 0 = sec, 1 = min, 2 = hour (interpreted as LOCAL hour), 3 = reserved, no effect
- SET_VAL  in  6  value to load
- TZ_INC  in  1  one-cycle strobe: offset +1 hour
- TZ_DEC  in  1  one-cycle strobe: offset −1 hour
- GMT_DATA  out  18  {hour[5:0],min[5:0],sec[5:0]}, GMT
- LOCAL_DATA  out  18  {hour,min,sec}, local time
- TZ_OFFSET  out  5  current offset, two's complement
- SEC_PULSE  out  1  one-cycle pulse each time the seconds field advances
- DAY_ROLL  out  1  one-cycle pulse when GMT rolls 23:59:59 → 00:00:00
- SET_ERR  out  1  one-cycle pulse when a set request is rejected

Behaviour:
- Reset values (asynchronous, while RESETN=0):
  - GMT = RESET_HOUR:00:00; TZ_OFFSET = TZ_RESET; prescaler = 0.
  - SEC_PULSE = DAY_ROLL = SET_ERR = 0.
  - LOCAL_DATA = ((RESET_HOUR + TZ_RESET) mod 24):00:00.
- Prescaler:
  - Counts 0..TICK_DIV−1 while RUN=1.
  - Internal tick asserts in the cycle the count equals TICK_DIV−1; the count wraps to 0 in that cycle.
  - With TICK_DIV=1, tick asserts every cycle.
- Advance on tick (all updates in the same edge):
  - sec: 0..59, wraps to 0.
  - min: increments only when sec=59; 0..59, wraps to 0.
  - hour: increments only when min=59 and sec=59; 0..23, wraps to 0.
  - SEC_PULSE = 1 on the cycle after each tick edge (registered).
  - DAY_ROLL = 1 together with SEC_PULSE when the transition was 23:59:59 → 00:00:00.
- Set:
  - SET_EN has priority over tick in the same cycle: the selected field loads, no field advances, prescaler clears to 0.
  - sec/min: accepted if SET_VAL ≤ 59.
  - hour: accepted if SET_VAL ≤ 23; the stored value is GMT hour = (SET_VAL − TZ_OFFSET) mod 24.
  - Out-of-range value or SET_SEL=3: no state change; SET_ERR pulses one cycle. The prescaler is still cleared.
  - Set is honoured regardless of RUN.
- Timezone:
  - TZ_INC alone: offset +1, saturating at TZ_MAX.
  - TZ_DEC alone: offset −1, saturating at TZ_MIN.
  - Both asserted in the same cycle: no change.
  - Changing the offset never modifies GMT.
  - TZ strobes may coincide with SET_EN: the hour-set conversion uses the offset value from before the edge.
- Local time:
  - min and sec equal GMT min and sec.
  - local hour = (GMT hour + TZ_OFFSET) mod 24, with a non-negative result for negative sums.
  - LOCAL_DATA is registered and lags GMT_DATA and TZ_OFFSET by exactly 1 cycle.
- Arithmetic: hour math is done in ≥7-bit signed intermediates; the modulo is implemented by a single conditional ±24 correction.
- Reset mid-operation: asynchronous return to the reset values; a pending strobe is discarded.

Test Plan:
- Reset with RESETN=0, TICK_DIV=4 → after release GMT_DATA = 15:00:00 and LOCAL_DATA = 00:00:00 (15+9 = 24 → 0); TZ_OFFSET = 9.
- RUN=1, TICK_DIV=4, clock 12 cycles → sec = 3; SEC_PULSE high for exactly 3 single cycles, spaced 4 cycles apart.
- SET hour 23 (local), min 59, sec 59 with tz=0, then one tick → GMT = 00:00:00; DAY_ROLL and SEC_PULSE both pulse once.
- TZ_DEC ×30 from tz=9 → TZ_OFFSET saturates at −12 (5'b10100). With GMT hour 3, LOCAL hour = 15 one cycle later; GMT is unchanged.
- SET_SEL=1 with SET_VAL=60 → SET_ERR pulses one cycle and min is unchanged. SET_SEL=3 → SET_ERR pulses one cycle and no field changes.
- SET_EN coincident with tick, and TZ_INC coincident with TZ_DEC → set field loads with no advance, prescaler reads 0 next cycle, offset is unchanged.
